// File: rtl/fft_round_pkg.sv
// ----------------------------------------------------------------------------
// fft_round_pkg : default widths, result type and round-half-even helper
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

package fft_round_pkg;

  localparam int IN_W  = 27;
  localparam int OUT_W = 11;
  localparam int LSB   = 12;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             sat;
  } round_res_t;

  // Round-half-even with saturation on round-up overflow, at the default widths.
  function automatic round_res_t round_half_even_sat(input logic [IN_W-1:0] d);
    round_res_t       res;
    logic [OUT_W-1:0] t;
    logic             up;
    t  = d[LSB+OUT_W-1:LSB];
    up = d[LSB-1] & ((|d[LSB-2:0]) | d[LSB]);
    res.sat  = up & (&t);
    res.data = res.sat ? {OUT_W{1'b1}} : t + OUT_W'(up);
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_round_unit.sv
// ----------------------------------------------------------------------------
// fft_round_unit : combinational round-half-even + saturate, IN_W -> OUT_W
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module fft_round_unit
  import fft_round_pkg::*;
#(
  parameter int IN_W  = fft_round_pkg::IN_W,
  parameter int OUT_W = fft_round_pkg::OUT_W,
  parameter int LSB   = fft_round_pkg::LSB
) (
  input  logic [IN_W-1:0]  d_i,
  output logic [OUT_W-1:0] result_o,
  output logic             sat_o
);

  logic [OUT_W-1:0] trunc_w;
  logic             guard_w;
  logic             sticky_w;
  logic             up_w;

  assign trunc_w  = d_i[LSB+OUT_W-1:LSB];
  assign guard_w  = d_i[LSB-1];
  assign sticky_w = |d_i[LSB-2:0];
  // Ties round toward the even neighbour, hence the kept LSB joins the sticky bit.
  assign up_w     = guard_w & (sticky_w | d_i[LSB]);

  assign sat_o    = up_w & (&trunc_w);
  assign result_o = sat_o ? {OUT_W{1'b1}} : trunc_w + OUT_W'(up_w);

  generate
    if (IN_W > LSB + OUT_W) begin : g_headroom
      // Headroom bits are zero by construction upstream and carry no information.
      logic unused_headroom;
      assign unused_headroom = ^d_i[IN_W-1:LSB+OUT_W];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/fft_round_arbiter.sv
// ----------------------------------------------------------------------------
// fft_round_arbiter : two-requester round-robin front end to one shared rounder
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module fft_round_arbiter
  import fft_round_pkg::*;
#(
  parameter int IN_W      = fft_round_pkg::IN_W,
  parameter int OUT_W     = fft_round_pkg::OUT_W,
  parameter int LSB       = fft_round_pkg::LSB,
  parameter int SAT_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [IN_W-1:0]      req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [IN_W-1:0]      req1_data,
  output logic                 req1_ready,
  output logic                 out_valid,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_src,
  output logic                 out_sat,
  input  logic                 out_ready,
  output logic [SAT_CNT_W-1:0] sat_count
);

  logic                 prio_q, prio_d;
  logic                 valid_q, valid_d;
  logic [OUT_W-1:0]     data_q, data_d;
  logic                 src_q, src_d;
  logic                 sat_q, sat_d;
  logic [SAT_CNT_W-1:0] cnt_q, cnt_d;

  logic             can_accept_w;
  logic             grant0_w;
  logic             grant1_w;
  logic             accept_w;
  logic [IN_W-1:0]  sel_data_w;
  logic [OUT_W-1:0] rnd_data_w;
  logic             rnd_sat_w;

  // prio_q names the requester that wins a tie; it is the one not granted last.
  assign can_accept_w = ~valid_q | out_ready;
  assign grant0_w     = req0_valid & (~req1_valid | ~prio_q);
  assign grant1_w     = req1_valid & (~req0_valid |  prio_q);
  assign req0_ready   = grant0_w & can_accept_w & ~rst;
  assign req1_ready   = grant1_w & can_accept_w & ~rst;
  assign accept_w     = req0_ready | req1_ready;
  assign sel_data_w   = grant1_w ? req1_data : req0_data;

  fft_round_unit #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .LSB   (LSB)
  ) u_round (
    .d_i      (sel_data_w),
    .result_o (rnd_data_w),
    .sat_o    (rnd_sat_w)
  );

  always_comb begin
    prio_d  = prio_q;
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    if (can_accept_w) begin
      valid_d = accept_w;
      if (accept_w) begin
        data_d = rnd_data_w;
        src_d  = req1_ready;
        sat_d  = rnd_sat_w;
        prio_d = ~req1_ready;
        if (rnd_sat_w && !(&cnt_q)) begin
          cnt_d = cnt_q + SAT_CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= 1'b0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      prio_q  <= prio_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign out_sat   = sat_q;
  assign sat_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_round_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fft_round_arbiter : directed + random stimulus against a behavioural model
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fft_round_arbiter;

  localparam int IN_W      = 27;
  localparam int OUT_W     = 11;
  localparam int LSB       = 12;
  localparam int SAT_CNT_W = 8;
  localparam int OUT_MAX   = (1 << OUT_W) - 1;
  localparam int CNT_MAX   = (1 << SAT_CNT_W) - 1;
  localparam int HALF      = 1 << (LSB - 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 req0_valid = 1'b0;
  logic [IN_W-1:0]      req0_data = '0;
  logic                 req0_ready;
  logic                 req1_valid = 1'b0;
  logic [IN_W-1:0]      req1_data = '0;
  logic                 req1_ready;
  logic                 out_valid;
  logic [OUT_W-1:0]     out_data;
  logic                 out_src;
  logic                 out_sat;
  logic                 out_ready = 1'b1;
  logic [SAT_CNT_W-1:0] sat_count;

  fft_round_arbiter #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .LSB       (LSB),
    .SAT_CNT_W (SAT_CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_sat    (out_sat),
    .out_ready  (out_ready),
    .sat_count  (sat_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: what the output register and counter should hold.
  bit m_valid = 1'b0;
  int m_data  = 0;
  int m_src   = 0;
  int m_sat   = 0;
  int m_cnt   = 0;
  int m_last  = 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-half-even on plain integers: kept value, remainder against one half.
  task automatic ref_round(input logic [IN_W-1:0] d, output int r, output int s);
    int kept;
    int rem;
    int up;
    kept = int'((d >> LSB) % (1 << OUT_W));
    rem  = int'(d % (1 << LSB));
    up   = ((rem > HALF) || (rem == HALF && (kept % 2) == 1)) ? 1 : 0;
    if (kept + up > OUT_MAX) begin
      r = OUT_MAX;
      s = 1;
    end else begin
      r = kept + up;
      s = 0;
    end
  endtask

  task automatic step(input bit v0, input logic [IN_W-1:0] d0,
                      input bit v1, input logic [IN_W-1:0] d1, input bit ordy);
    bit can;
    int g;
    int r;
    int s;
    @(negedge clk);
    rst        = 1'b0;
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    out_ready  = ordy;
    #1;
    can = !m_valid || ordy;
    g   = -1;
    if (v0 && v1)  g = (m_last == 0) ? 1 : 0;
    else if (v0)   g = 0;
    else if (v1)   g = 1;
    if (!can) g = -1;
    check_eq("ready0", 32'(req0_ready), 32'(g == 0));
    check_eq("ready1", 32'(req1_ready), 32'(g == 1));
    check_eq("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check_eq("out_data", 32'(out_data), 32'(m_data));
      check_eq("out_src", 32'(out_src), 32'(m_src));
      check_eq("out_sat", 32'(out_sat), 32'(m_sat));
    end
    check_eq("sat_count", 32'(sat_count), 32'(m_cnt));
    if (can) begin
      if (g >= 0) begin
        ref_round((g == 0) ? d0 : d1, r, s);
        m_valid = 1'b1;
        m_data  = r;
        m_sat   = s;
        m_src   = g;
        m_last  = g;
        if (s == 1 && m_cnt < CNT_MAX) m_cnt++;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    req0_valid = 1'($urandom);
    req1_valid = 1'($urandom);
    out_ready  = 1'($urandom);
    #1;
    check_eq("rst_ready0", 32'(req0_ready), 32'd0);
    check_eq("rst_ready1", 32'(req1_ready), 32'd0);
    m_valid = 1'b0;
    m_cnt   = 0;
    m_last  = 1;
  endtask

  function automatic logic [IN_W-1:0] rand_sample();
    logic [IN_W-1:0] d;
    d = IN_W'($urandom) & IN_W'((1 << (LSB + OUT_W)) - 1);
    case ($urandom_range(0, 3))
      0: d[LSB-1:0] = LSB'(HALF);
      1: d[LSB+OUT_W-1:LSB] = '1;
      default: ;
    endcase
    return d;
  endfunction

  initial begin
    do_reset();
    @(negedge clk);
    #1;
    check_eq("reset_valid", 32'(out_valid), 32'd0);
    check_eq("reset_data", 32'(out_data), 32'd0);
    check_eq("reset_src", 32'(out_src), 32'd0);
    check_eq("reset_sat", 32'(out_sat), 32'd0);
    check_eq("reset_cnt", 32'(sat_count), 32'd0);

    // Rounding ties, sticky bits and saturation on fixed samples.
    step(1, 27'h0001800, 0, '0, 1);
    step(1, 27'h0000800, 0, '0, 1);
    check_eq("t1_tie_up", 32'(out_data), 32'h002);
    step(1, 27'h0000801, 0, '0, 1);
    check_eq("t1_tie_even", 32'(out_data), 32'h000);
    step(0, '0, 1, 27'h07FF800, 1);
    check_eq("t1_sticky", 32'(out_data), 32'h001);
    step(0, '0, 0, '0, 1);
    check_eq("t2_sat_data", 32'(out_data), 32'h7FF);
    check_eq("t2_sat_flag", 32'(out_sat), 32'd1);
    check_eq("t2_sat_cnt", 32'(sat_count), 32'd1);

    // Contention, then a stall with both requesters waiting.
    for (int i = 0; i < 6; i++) step(1, rand_sample(), 1, rand_sample(), 1);
    for (int i = 0; i < 3; i++) step(1, rand_sample(), 1, rand_sample(), 0);
    for (int i = 0; i < 3; i++) step(1, rand_sample(), 1, rand_sample(), 1);

    // Counter saturation.
    for (int i = 0; i < 300; i++) step(0, '0, 1, 27'h07FFFFF, 1);
    step(0, '0, 0, '0, 1);
    check_eq("t5_cnt_max", 32'(sat_count), 32'(CNT_MAX));

    // Reset while stalled on a held result.
    step(0, '0, 1, 27'h0002000, 1);
    step(1, rand_sample(), 1, rand_sample(), 0);
    do_reset();
    step(1, rand_sample(), 1, rand_sample(), 1);
    check_eq("t6_first_grant", 32'(req0_ready), 32'd1);

    for (int i = 0; i < 500; i++) begin
      step(1'($urandom), rand_sample(), 1'($urandom), rand_sample(), $urandom_range(0, 3) != 0);
    end
    step(0, '0, 0, '0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
